// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic {
    ST_RUN,
    ST_REDIRECT
  } hz_state_e;

  localparam int FWD_RF = 0;

  // Decoder flag positions used to derive ra_we / ra_jalr.
  localparam int FLAG_WE_BIT   = 0;
  localparam int FLAG_JALR_BIT = 10;

endpackage

// File: rtl/hazard_match.sv
// Matches one source against N pending writers; reports the youngest hit.
module hazard_match #(
  parameter int AW = 5,
  parameter int N  = 2,
  parameter int IW = 2
) (
  input  logic [AW-1:0]   src,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] rd,
  input  logic [N-1:0]    is_load,
  output logic            hit,
  output logic [IW-1:0]   idx,
  output logic            load_hit
);

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    load_hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (we[k] && rd[k*AW +: AW] != '0
          && rd[k*AW +: AW] == src) begin
        hit      = 1'b1;
        idx      = IW'(k);
        load_hit = is_load[k];
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/forward control, JALR redirect FSM, stall counter and watchdog.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int N_LATE          = 2,
  parameter int FWD_MODE        = 0,
  parameter int REDIRECT_CYCLES = 2,
  parameter int STALL_LIMIT     = 64,
  parameter int CNT_W           = 16,
  parameter int SEL_W           = $clog2(N_LATE + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dec_valid,
  input  logic [REG_AW-1:0]        dec_rs1,
  input  logic [REG_AW-1:0]        dec_rs2,
  input  logic                     ra_valid,
  input  logic                     ra_we,
  input  logic [REG_AW-1:0]        ra_rd,
  input  logic [REG_AW-1:0]        ra_rs1,
  input  logic [REG_AW-1:0]        ra_rs2,
  input  logic                     ra_jalr,
  input  logic [N_LATE-1:0]        late_we,
  input  logic [N_LATE-1:0]        late_is_load,
  input  logic [N_LATE*REG_AW-1:0] late_rd,
  input  logic                     cnt_clear,
  output logic                     fetch_en,
  output logic                     decoded_latch_en,
  output logic                     reg_access_latch_en,
  output logic                     alu_latch_en,
  output logic                     flush_decoded,
  output logic                     jmpctrl_en,
  output logic [SEL_W-1:0]         fwd_rs1_sel,
  output logic [SEL_W-1:0]         fwd_rs2_sel,
  output logic [CNT_W-1:0]         stall_count,
  output logic                     deadlock_err
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [2:0] RCNT_INIT = 3'(REDIRECT_CYCLES - 1);

  // Decoded sources also see reg_access as the youngest writer.
  logic [N_LATE:0]            dw_we;
  logic [N_LATE:0]            dw_ld;
  logic [(N_LATE+1)*REG_AW-1:0] dw_rd;

  assign dw_we = {late_we, ra_we};
  assign dw_ld = {late_is_load, 1'b0};
  assign dw_rd = {late_rd, ra_rd};

  logic             d1_hit, d2_hit, r1_hit, r2_hit;
  logic             d1_ld, d2_ld, r1_ld, r2_ld;
  logic [SEL_W-1:0] d1_idx, d2_idx, r1_idx, r2_idx;
  logic             unused_dec;

  assign unused_dec = ^{d1_ld, d2_ld, d1_idx, d2_idx};

  hazard_match #(.AW(REG_AW), .N(N_LATE + 1), .IW(SEL_W)) u_d1 (
    .src(dec_rs1), .we(dw_we), .rd(dw_rd), .is_load(dw_ld),
    .hit(d1_hit), .idx(d1_idx), .load_hit(d1_ld)
  );

  hazard_match #(.AW(REG_AW), .N(N_LATE + 1), .IW(SEL_W)) u_d2 (
    .src(dec_rs2), .we(dw_we), .rd(dw_rd), .is_load(dw_ld),
    .hit(d2_hit), .idx(d2_idx), .load_hit(d2_ld)
  );

  hazard_match #(.AW(REG_AW), .N(N_LATE), .IW(SEL_W)) u_r1 (
    .src(ra_rs1), .we(late_we), .rd(late_rd),
    .is_load(late_is_load),
    .hit(r1_hit), .idx(r1_idx), .load_hit(r1_ld)
  );

  hazard_match #(.AW(REG_AW), .N(N_LATE), .IW(SEL_W)) u_r2 (
    .src(ra_rs2), .we(late_we), .rd(late_rd),
    .is_load(late_is_load),
    .hit(r2_hit), .idx(r2_idx), .load_hit(r2_ld)
  );

  logic dec_blk, ra_blk, stall;

  always_comb begin
    dec_blk     = 1'b0;
    ra_blk      = 1'b0;
    fwd_rs1_sel = SEL_W'(FWD_RF);
    fwd_rs2_sel = SEL_W'(FWD_RF);
    if (FWD_MODE == 0) begin
      dec_blk = dec_valid && (d1_hit || d2_hit);
      ra_blk  = ra_valid && (r1_hit || r2_hit);
    end else begin
      // Only a load still in the ALU stage forces a bubble.
      ra_blk = ra_valid && late_is_load[0]
            && ((r1_hit && r1_idx == '0)
             || (r2_hit && r2_idx == '0));
      if (r1_hit && !r1_ld)
        fwd_rs1_sel = r1_idx + SEL_W'(1);
      if (r2_hit && !r2_ld)
        fwd_rs2_sel = r2_idx + SEL_W'(1);
    end
  end

  assign stall = dec_blk || ra_blk;

  hz_state_e  state_q, state_d;
  logic [2:0] rcnt_q, rcnt_d;
  logic       redir;

  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    jmpctrl_en    = 1'b0;
    flush_decoded = 1'b0;
    redir         = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        jmpctrl_en = ra_valid && ra_jalr && !ra_blk;
        if (jmpctrl_en) begin
          flush_decoded = 1'b1;
          state_d       = ST_REDIRECT;
          rcnt_d        = RCNT_INIT;
        end
      end
      ST_REDIRECT: begin
        flush_decoded = 1'b1;
        redir         = 1'b1;
        if (rcnt_q == '0)
          state_d = ST_RUN;
        else
          rcnt_d = rcnt_q - 3'd1;
      end
    endcase
  end

  assign alu_latch_en        = 1'b1;
  assign reg_access_latch_en = !ra_blk;
  assign decoded_latch_en    = !stall;
  assign fetch_en            = !stall && !redir;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear)
      cnt_d = '0;
    else if (stall && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
    run_d = '0;
    if (stall)
      run_d = (run_q == RUN_W'(STALL_LIMIT))
            ? run_q : run_q + RUN_W'(1);
    err_d = err_q
         || (stall && run_q == RUN_W'(STALL_LIMIT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign stall_count  = cnt_q;
  assign deadlock_err = err_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench: stall-only (CNT_W=4) and forwarding instances vs a reference model.
module tb_pipeline_hazard_unit;

  localparam int REDIR = 2;
  localparam int LIMIT = 64;

  logic       clk, rst_n;
  logic       dec_valid, ra_valid, ra_we, ra_jalr, cnt_clear;
  logic [4:0] dec_rs1, dec_rs2, ra_rd, ra_rs1, ra_rs2;
  logic [1:0] late_we, late_is_load;
  logic [9:0] late_rd;

  logic       fe[2], de[2], rae[2], ae[2];
  logic       fl[2], jm[2], derr[2];
  logic [1:0] s1[2], s2[2];
  logic [3:0] sc0;
  logic [15:0] sc1;

  int checks, failures;

  pipeline_hazard_unit #(.FWD_MODE(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .ra_valid(ra_valid), .ra_we(ra_we), .ra_rd(ra_rd),
    .ra_rs1(ra_rs1), .ra_rs2(ra_rs2), .ra_jalr(ra_jalr),
    .late_we(late_we), .late_is_load(late_is_load),
    .late_rd(late_rd), .cnt_clear(cnt_clear),
    .fetch_en(fe[0]), .decoded_latch_en(de[0]),
    .reg_access_latch_en(rae[0]), .alu_latch_en(ae[0]),
    .flush_decoded(fl[0]), .jmpctrl_en(jm[0]),
    .fwd_rs1_sel(s1[0]), .fwd_rs2_sel(s2[0]),
    .stall_count(sc0), .deadlock_err(derr[0])
  );

  pipeline_hazard_unit #(.FWD_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .ra_valid(ra_valid), .ra_we(ra_we), .ra_rd(ra_rd),
    .ra_rs1(ra_rs1), .ra_rs2(ra_rs2), .ra_jalr(ra_jalr),
    .late_we(late_we), .late_is_load(late_is_load),
    .late_rd(late_rd), .cnt_clear(cnt_clear),
    .fetch_en(fe[1]), .decoded_latch_en(de[1]),
    .reg_access_latch_en(rae[1]), .alu_latch_en(ae[1]),
    .flush_decoded(fl[1]), .jmpctrl_en(jm[1]),
    .fwd_rs1_sel(s1[1]), .fwd_rs2_sel(s2[1]),
    .stall_count(sc1), .deadlock_err(derr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one slot per instance.
  int m_redir[2], m_cnt[2], m_run[2];
  bit m_err[2];

  function automatic bit mt(logic [4:0] src, int k);
    logic [4:0] r;
    r = late_rd[k*5 +: 5];
    return late_we[k] && r != 0 && r == src;
  endfunction

  function automatic bit mra(logic [4:0] src);
    return ra_we && ra_rd != 0 && ra_rd == src;
  endfunction

  function automatic bit f_dec_blk(int m);
    if (m == 1 || !dec_valid) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (mt(dec_rs1, k) || mt(dec_rs2, k)) return 1'b1;
    return mra(dec_rs1) || mra(dec_rs2);
  endfunction

  function automatic bit f_ra_blk(int m);
    if (!ra_valid) return 1'b0;
    if (m == 1)
      return late_is_load[0] && (mt(ra_rs1, 0) || mt(ra_rs2, 0));
    for (int k = 0; k < 2; k++)
      if (mt(ra_rs1, k) || mt(ra_rs2, k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit f_stall(int m);
    return f_dec_blk(m) || f_ra_blk(m);
  endfunction

  function automatic int f_sel(int m, logic [4:0] src);
    if (m == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (mt(src, k)) return late_is_load[k] ? 0 : k + 1;
    return 0;
  endfunction

  function automatic logic [10:0] f_exp(int m);
    bit st, rb, rdr, fire;
    st   = f_stall(m);
    rb   = f_ra_blk(m);
    rdr  = m_redir[m] > 0;
    fire = !rdr && ra_valid && ra_jalr && !rb;
    return {!st && !rdr, !st, !rb, 1'b1, fire || rdr, fire,
            2'(f_sel(m, ra_rs1)), 2'(f_sel(m, ra_rs2)), m_err[m]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_redir[m] <= 0;
        m_cnt[m]   <= 0;
        m_run[m]   <= 0;
        m_err[m]   <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (m_redir[m] > 0)
          m_redir[m] <= m_redir[m] - 1;
        else if (ra_valid && ra_jalr && !f_ra_blk(m))
          m_redir[m] <= REDIR;
        if (cnt_clear)
          m_cnt[m] <= 0;
        else if (f_stall(m) && m_cnt[m] < (m == 0 ? 15 : 65535))
          m_cnt[m] <= m_cnt[m] + 1;
        m_run[m] <= f_stall(m) ? m_run[m] + 1 : 0;
        if (f_stall(m) && m_run[m] + 1 >= LIMIT)
          m_err[m] <= 1'b1;
      end
    end
  end

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0;
    ra_valid = 0; ra_we = 0; ra_rd = 0;
    ra_rs1 = 0; ra_rs2 = 0; ra_jalr = 0;
    late_we = 0; late_is_load = 0; late_rd = 0;
    cnt_clear = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #3;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({fe[m], de[m], rae[m], ae[m], fl[m], jm[m], derr[m]}
          !== 7'b1111000) begin
        failures++;
        $display("FAIL reset_outs m=%0d got=%b%b%b%b%b%b%b want=1111000",
                 m, fe[m], de[m], rae[m], ae[m], fl[m], jm[m], derr[m]);
      end
    end
    checks++;
    if (sc0 !== 4'd0 || sc1 !== 16'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", sc0, sc1);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_raw_stall();
    do_reset();
    ra_valid = 1; ra_rs1 = 5; late_we = 2'b01; late_rd = 10'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({fe[0], de[0], rae[0], ae[0]} !== 4'b0001) begin
        failures++;
        $display("FAIL raw_en cyc=%0d got=%b%b%b%b want=0001",
                 i, fe[0], de[0], rae[0], ae[0]);
      end
      checks++;
      if (sc0 !== 4'(i)) begin
        failures++;
        $display("FAIL raw_cnt cyc=%0d got=%0d want=%0d", i, sc0, i);
      end
      @(negedge clk);
    end
    late_rd = 10'd0;
    #1;
    checks++;
    if ({fe[0], rae[0]} !== 2'b11 || sc0 !== 4'd3) begin
      failures++;
      $display("FAIL raw_x0 got fe=%b ra=%b cnt=%0d want 1 1 3",
               fe[0], rae[0], sc0);
    end
    @(negedge clk);
  endtask

  task automatic test_forward();
    idle();
    ra_valid = 1; ra_rs2 = 7; late_we = 2'b11;
    late_rd = {5'd7, 5'd7};
    #1;
    checks++;
    if (s2[1] !== 2'd1 || s1[1] !== 2'd0 || rae[1] !== 1'b1
        || fe[1] !== 1'b1) begin
      failures++;
      $display("FAIL fwd_young got s2=%0d s1=%0d ra=%b fe=%b want 1 0 1 1",
               s2[1], s1[1], rae[1], fe[1]);
    end
    checks++;
    if (s2[0] !== 2'd0) begin
      failures++;
      $display("FAIL fwd_mode0 got=%0d want=0", s2[0]);
    end
    @(negedge clk);
    late_we = 2'b10;
    #1;
    checks++;
    if (s2[1] !== 2'd2) begin
      failures++;
      $display("FAIL fwd_old got=%0d want=2", s2[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    idle();
    ra_valid = 1; ra_rs1 = 3; late_we = 2'b01;
    late_rd = 10'd3; late_is_load = 2'b01;
    #1;
    checks++;
    if ({fe[1], de[1], rae[1], ae[1]} !== 4'b0001 || s1[1] !== 2'd0) begin
      failures++;
      $display("FAIL lu_stall got=%b%b%b%b sel=%0d want=0001 sel=0",
               fe[1], de[1], rae[1], ae[1], s1[1]);
    end
    @(negedge clk);
    late_we = 2'b10; late_rd = {5'd3, 5'd0}; late_is_load = 2'b00;
    #1;
    checks++;
    if ({fe[1], de[1], rae[1]} !== 3'b111 || s1[1] !== 2'd2) begin
      failures++;
      $display("FAIL lu_release got=%b%b%b sel=%0d want=111 sel=2",
               fe[1], de[1], rae[1], s1[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_jalr();
    logic [3:0] wj, wf, we_;
    do_reset();
    wj = 4'b0001; wf = 4'b0111; we_ = 4'b1001;
    ra_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ra_jalr = (i < 2);
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if ({jm[m], fl[m], fe[m]} !== {wj[i], wf[i], we_[i]}) begin
          failures++;
          $display("FAIL jalr_seq m=%0d cyc=%0d got=%b%b%b want=%b%b%b",
                   m, i, jm[m], fl[m], fe[m], wj[i], wf[i], we_[i]);
        end
      end
      @(negedge clk);
    end
    ra_jalr = 1; ra_rs1 = 3; late_we = 2'b01;
    late_rd = 10'd3; late_is_load = 2'b01;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({jm[m], fl[m]} !== 2'b00) begin
        failures++;
        $display("FAIL jalr_stalled m=%0d got=%b%b want=00",
                 m, jm[m], fl[m]);
      end
    end
    @(negedge clk);
    late_we = 2'b00;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({jm[m], fl[m]} !== 2'b11) begin
        failures++;
        $display("FAIL jalr_release m=%0d got=%b%b want=11",
                 m, jm[m], fl[m]);
      end
    end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_redirect();
    idle();
    ra_valid = 1; ra_jalr = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({fl[1], fe[1], jm[1]} !== 3'b100) begin
      failures++;
      $display("FAIL mid_redir got=%b%b%b want=100", fl[1], fe[1], jm[1]);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({fe[1], fl[1], jm[1]} !== 3'b111 || sc1 !== 16'd0
        || derr[1] !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got=%b%b%b cnt=%0d err=%b want=111 0 0",
               fe[1], fl[1], jm[1], sc1, derr[1]);
    end
    ra_jalr = 0;
    #1;
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({fe[1], fl[1], jm[1]} !== 3'b100) begin
      failures++;
      $display("FAIL post_rst got=%b%b%b want=100", fe[1], fl[1], jm[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate_watchdog();
    do_reset();
    ra_valid = 1; ra_rs1 = 5; late_we = 2'b01;
    late_rd = 10'd5; late_is_load = 2'b01;
    for (int i = 0; i < 70; i++) begin
      #1;
      checks++;
      if (derr[0] !== (i >= LIMIT) || derr[1] !== (i >= LIMIT)) begin
        failures++;
        $display("FAIL wdog cyc=%0d got=%b%b want=%b",
                 i, derr[0], derr[1], i >= LIMIT);
      end
      checks++;
      if (sc0 !== 4'(i < 15 ? i : 15) || sc1 !== 16'(i)) begin
        failures++;
        $display("FAIL sat_cnt cyc=%0d got=%0d/%0d want=%0d/%0d",
                 i, sc0, sc1, i < 15 ? i : 15, i);
      end
      @(negedge clk);
    end
    cnt_clear = 1;
    @(negedge clk);
    #1;
    checks++;
    if (sc0 !== 4'd0 || derr[0] !== 1'b1 || derr[1] !== 1'b1) begin
      failures++;
      $display("FAIL clr_stall got cnt=%0d err=%b%b want 0 11",
               sc0, derr[0], derr[1]);
    end
    cnt_clear = 0;
    @(negedge clk);
    #1;
    checks++;
    if (sc0 !== 4'd1) begin
      failures++;
      $display("FAIL clr_resume got=%0d want=1", sc0);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [10:0] got;
    int sc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      dec_valid = 1'($urandom);
      dec_rs1 = 5'($urandom_range(0, 7));
      dec_rs2 = 5'($urandom_range(0, 7));
      ra_valid = 1'($urandom);
      ra_we = 1'($urandom);
      ra_rd = 5'($urandom_range(0, 7));
      ra_rs1 = 5'($urandom_range(0, 7));
      ra_rs2 = 5'($urandom_range(0, 7));
      ra_jalr = ($urandom_range(0, 3) == 0);
      late_we = 2'($urandom);
      late_is_load = 2'($urandom);
      late_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cnt_clear = ($urandom_range(0, 15) == 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        got = {fe[m], de[m], rae[m], ae[m], fl[m], jm[m],
               s1[m], s2[m], derr[m]};
        checks++;
        if (got !== f_exp(m)) begin
          failures++;
          $display("FAIL rnd_outs m=%0d cyc=%0d got=%b want=%b",
                   m, i, got, f_exp(m));
        end
        sc = (m == 0) ? int'(sc0) : int'(sc1);
        checks++;
        if (sc != m_cnt[m]) begin
          failures++;
          $display("FAIL rnd_cnt m=%0d cyc=%0d got=%0d want=%0d",
                   m, i, sc, m_cnt[m]);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_raw_stall();
    test_forward();
    test_load_use();
    test_jalr();
    test_reset_mid_redirect();
    test_saturate_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
